// File: rtl/ternary_pkg.sv
// Shared ternary types plus the branch-prediction queue entry used by the resolver.
// Trits are two-bit balanced digits: 00 is zero, 01 is +1 and 11 is -1.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b11;

    localparam int BP_DEFAULT_DEPTH = 4;
    localparam int BP_PC_TRITS      = 9;
    localparam int BP_CNT_W         = 16;

    typedef trit_t [BP_PC_TRITS-1:0] bp_pc_t;

    typedef struct packed {
        logic   taken;
        bp_pc_t fall_pc;
        bp_pc_t target_pc;
    } bp_entry_t;

    // Balanced-ternary encode; each remainder is folded into the digit set {-1, 0, +1}.
    function automatic bp_pc_t int_to_trits(input int value);
        bp_pc_t pc;
        int     v;
        int     r;
        v = value;
        for (int i = 0; i < BP_PC_TRITS; i++) begin
            r = ((v % 3) + 3) % 3;
            if (r == 1) begin
                pc[i] = T_POS;
                v     = (v - 1) / 3;
            end else if (r == 2) begin
                pc[i] = T_NEG;
                v     = (v + 1) / 3;
            end else begin
                pc[i] = T_ZERO;
                v     = v / 3;
            end
        end
        return pc;
    endfunction

    function automatic int trits_to_int(input bp_pc_t pc);
        int acc;
        acc = 0;
        for (int i = BP_PC_TRITS - 1; i >= 0; i--) begin
            if (pc[i] == T_POS) begin
                acc = acc * 3 + 1;
            end else if (pc[i] == T_NEG) begin
                acc = acc * 3 - 1;
            end else begin
                acc = acc * 3;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/ternary_bp_fifo.sv
// In-order queue of predicted branches awaiting resolution.
// Clear discards every entry and has priority over a push in the same cycle.
module ternary_bp_fifo
    import ternary_pkg::*;
#(
    parameter int DEPTH = BP_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  bp_entry_t                push_data,
    input  logic                     pop,
    input  logic                     clear,
    output bp_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    bp_entry_t        mem_q [DEPTH];
    bp_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ternary_branch_resolver.sv
// Resolves queued static branch predictions in program order against execute outcomes,
// producing a registered flush/redirect on mispredicts plus saturating statistics.
module ternary_branch_resolver
    import ternary_pkg::*;
#(
    parameter int DEPTH    = BP_DEFAULT_DEPTH,
    parameter int PC_TRITS = BP_PC_TRITS,
    parameter int CNT_W    = BP_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pred_valid,
    output logic                        pred_ready,
    input  logic                        pred_taken,
    input  trit_t [PC_TRITS-1:0]        pred_fall_pc,
    input  trit_t [PC_TRITS-1:0]        pred_target_pc,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic                        res_taken,
    output logic                        flush,
    output trit_t [PC_TRITS-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0]      inflight,
    output logic [CNT_W-1:0]            branch_cnt,
    output logic [CNT_W-1:0]            mispredict_cnt,
    output logic                        order_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    bp_entry_t push_entry;
    bp_entry_t head;
    logic      q_full;
    logic      q_empty;
    logic      pred_fire;
    logic      res_fire;
    logic      mispredict;

    logic                  flush_q, flush_d;
    trit_t [PC_TRITS-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]      branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]      mispredict_cnt_q, mispredict_cnt_d;
    logic                  order_err_q, order_err_d;

    assign push_entry = '{taken: pred_taken, fall_pc: pred_fall_pc, target_pc: pred_target_pc};

    assign pred_ready = !q_full && !flush_q;
    assign res_ready  = !q_empty && !flush_q;
    assign pred_fire  = pred_valid && pred_ready;
    assign res_fire   = res_valid && res_ready;
    assign mispredict = res_fire && (res_taken != head.taken);

    // Entries still queued during the flush cycle are all younger than the mispredict, so the
    // whole queue (including anything pushed alongside the mispredicting resolve) is dropped.
    ternary_bp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pred_fire),
        .push_data (push_entry),
        .pop       (res_fire),
        .clear     (flush_q),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (inflight)
    );

    always_comb begin
        flush_d          = mispredict;
        redirect_pc_d    = {PC_TRITS{T_ZERO}};
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        order_err_d      = order_err_q || (res_valid && q_empty);
        if (mispredict) begin
            redirect_pc_d = res_taken ? head.target_pc : head.fall_pc;
        end
        if (res_fire && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        if (mispredict && (mispredict_cnt_q != CNT_MAX)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q          <= 1'b0;
            redirect_pc_q    <= {PC_TRITS{T_ZERO}};
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            order_err_q      <= 1'b0;
        end else begin
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            order_err_q      <= order_err_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_pc    = redirect_pc_q;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
    assign order_err      = order_err_q;

endmodule

// File: tb/tb_ternary_branch_resolver.sv
// Directed scenarios followed by random traffic, all checked against a queue-based
// model of in-order branch resolution kept inside this bench.
module tb_ternary_branch_resolver;
    import ternary_pkg::*;

    localparam int DEPTH    = 4;
    localparam int PC_TRITS = 9;
    localparam int CNT_W    = 16;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   pred_valid;
    logic                   pred_ready;
    logic                   pred_taken;
    trit_t [PC_TRITS-1:0]   pred_fall_pc;
    trit_t [PC_TRITS-1:0]   pred_target_pc;
    logic                   res_valid;
    logic                   res_ready;
    logic                   res_taken;
    logic                   flush;
    trit_t [PC_TRITS-1:0]   redirect_pc;
    logic [$clog2(DEPTH):0] inflight;
    logic [CNT_W-1:0]       branch_cnt;
    logic [CNT_W-1:0]       mispredict_cnt;
    logic                   order_err;

    ternary_branch_resolver #(
        .DEPTH    (DEPTH),
        .PC_TRITS (PC_TRITS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_valid     (pred_valid),
        .pred_ready     (pred_ready),
        .pred_taken     (pred_taken),
        .pred_fall_pc   (pred_fall_pc),
        .pred_target_pc (pred_target_pc),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_taken      (res_taken),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .inflight       (inflight),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt),
        .order_err      (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit taken;
        int fall;
        int target;
    } branch_t;

    branch_t m_queue[$];
    bit      m_flush;
    int      m_redirect;
    int      m_branches;
    int      m_mispredicts;
    bit      m_order_err;

    int n_checks;
    int n_fail;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        m_queue.delete();
        m_flush       = 1'b0;
        m_redirect    = 0;
        m_branches    = 0;
        m_mispredicts = 0;
        m_order_err   = 1'b0;
    endtask

    task automatic checkRegistered(input string tag);
        checkOutput({tag, ".flush"}, flush, m_flush);
        checkOutput({tag, ".inflight"}, inflight, m_queue.size());
        checkOutput({tag, ".branch_cnt"}, branch_cnt, m_branches);
        checkOutput({tag, ".mispredict_cnt"}, mispredict_cnt, m_mispredicts);
        checkOutput({tag, ".order_err"}, order_err, m_order_err);
        if (m_flush) begin
            checkOutput({tag, ".redirect_pc"}, trits_to_int(redirect_pc), m_redirect);
        end
    endtask

    // One clock cycle: drive inputs, check readiness, advance the model at the edge,
    // then check every registered output one time unit after the edge.
    task automatic applyStimulus(input string tag, input bit pv, input bit pt, input int pf,
                                 input int ptg, input bit rv, input bit rt);
        bit      exp_pred_ready;
        bit      exp_res_ready;
        bit      next_flush;
        branch_t e;
        pred_valid     = pv;
        pred_taken     = pt;
        pred_fall_pc   = int_to_trits(pf);
        pred_target_pc = int_to_trits(ptg);
        res_valid      = rv;
        res_taken      = rt;
        #1;
        exp_pred_ready = (m_queue.size() < DEPTH) && !m_flush;
        exp_res_ready  = (m_queue.size() > 0) && !m_flush;
        checkOutput({tag, ".pred_ready"}, pred_ready, exp_pred_ready);
        checkOutput({tag, ".res_ready"}, res_ready, exp_res_ready);
        @(posedge clk);
        #1;
        next_flush = 1'b0;
        if (rv && m_queue.size() == 0) begin
            m_order_err = 1'b1;
        end
        if (m_flush) begin
            m_queue.delete();
        end else begin
            if (rv && exp_res_ready) begin
                e = m_queue.pop_front();
                if (m_branches < CNT_SAT) m_branches++;
                if (e.taken != rt) begin
                    if (m_mispredicts < CNT_SAT) m_mispredicts++;
                    next_flush = 1'b1;
                    m_redirect = rt ? e.target : e.fall;
                end
            end
            if (pv && exp_pred_ready) begin
                m_queue.push_back('{taken: pt, fall: pf, target: ptg});
            end
        end
        m_flush = next_flush;
        checkRegistered(tag);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        pred_valid     = 1'b0;
        pred_taken     = 1'b0;
        pred_fall_pc   = int_to_trits(0);
        pred_target_pc = int_to_trits(0);
        res_valid      = 1'b0;
        res_taken      = 1'b0;
        resetModel();

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkRegistered("reset");
        checkOutput("reset.redirect_zero", redirect_pc, 0);
        checkOutput("reset.pred_ready", pred_ready, 1);
        checkOutput("reset.res_ready", res_ready, 0);
        rst_n = 1'b1;

        // Correctly predicted taken branch.
        applyStimulus("t1_enq", 1'b1, 1'b1, 2, 5, 1'b0, 1'b0);
        applyStimulus("t1_res", 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        idleCycle("t1_idle");

        // Predicted not-taken but taken: redirect to the target.
        applyStimulus("t2_enq", 1'b1, 1'b0, 7, -3, 1'b0, 1'b0);
        applyStimulus("t2_res", 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        checkOutput("t2.redirect_abs", trits_to_int(redirect_pc), -3);
        idleCycle("t2_flush_cycle");
        idleCycle("t2_after");

        // Fill the queue, offer a fifth branch, then drain with matching outcomes.
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus("t3_fill", 1'b1, i[0], 10 + i, -10 - i, 1'b0, 1'b0);
        end
        checkOutput("t3.inflight_full", inflight, DEPTH);
        while (m_queue.size() > 0) begin
            applyStimulus("t3_drain", 1'b0, 1'b0, 0, 0, 1'b1, m_queue[0].taken);
        end

        // Mispredict the oldest of three while a fourth is enqueued in the same cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t4_enq", 1'b1, 1'b1, 100 + i, 200 + i, 1'b0, 1'b0);
        end
        applyStimulus("t4_mis", 1'b1, 1'b1, 300, 400, 1'b1, 1'b0);
        idleCycle("t4_flush_cycle");
        checkOutput("t4.inflight_zero", inflight, 0);
        idleCycle("t4_after");

        // Outcome with nothing in flight.
        applyStimulus("t5_orphan", 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        idleCycle("t5_sticky");
        idleCycle("t5_sticky2");

        // Reset while a flush is pending and entries remain queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("t6_enq", 1'b1, 1'b0, 50 + i, 60 + i, 1'b0, 1'b0);
        end
        applyStimulus("t6_mis", 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        resetModel();
        checkRegistered("t6_reset");
        checkOutput("t6_reset.redirect_zero", redirect_pc, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleCycle("t6_after");
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 99) < 60),
                          $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 4000)) - 2000,
                          int'($urandom_range(0, 4000)) - 2000,
                          ($urandom_range(0, 99) < 45),
                          $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
